// File: rtl/zdos_trap_if.sv
// Bus between the Z80 M1-cycle front end and the DOS-entry/exit sequencer.
// valid/ready: m1_start and cycle_end are 1-fclk pulses the slave cannot stall; the slave must take them in the cycle they occur.
interface zdos_trap_if;
  logic        m1_start;
  logic        cycle_end;
  logic [15:0] za;
  logic        romnram;
  logic        rom48;
  logic        dos;
  logic        cpm_n;
  logic        trdos_en;
  logic        dos_turn_on;
  logic        dos_turn_off;
  logic        busy;
  logic [7:0]  entry_cnt;
  logic [2:0]  fsm_state;

  modport master (
    output m1_start, cycle_end, za, romnram, rom48, dos, cpm_n, trdos_en,
    input  dos_turn_on, dos_turn_off, busy, entry_cnt, fsm_state
  );

  modport slave (
    input  m1_start, cycle_end, za, romnram, rom48, dos, cpm_n, trdos_en,
    output dos_turn_on, dos_turn_off, busy, entry_cnt, fsm_state
  );
endinterface

// File: rtl/zdos_trap.sv
// Issues dos_turn_on/dos_turn_off strobes from M1 opcode fetches: TR-DOS entry
// from the 48K ROM entry page, exit on any RAM fetch, with a lost-cycle-end watchdog.
module zdos_trap #(
  parameter logic [7:0]  ENTRY_HI = 8'h3D,
  parameter logic [15:0] RAM_BASE = 16'h4000,
  parameter logic [7:0]  TIMEOUT  = 8'd200
) (
  input logic       fclk,
  input logic       rst_n,
  zdos_trap_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_ON       = 3'd2,
    ST_OFF_WAIT = 3'd3,
    ST_WAIT_END = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] za_q, za_d;
  logic        romnram_q, romnram_d;
  logic        rom48_q, rom48_d;
  logic        dos_q, dos_d;
  logic        cpm_n_q, cpm_n_d;
  logic        trdos_en_q, trdos_en_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  entry_cnt_q, entry_cnt_d;
  logic        on_q, on_d;
  logic        off_q, off_d;

  logic capture;
  logic is_entry;
  logic is_exit;

  // A new fetch may pre-empt a cycle whose end was never seen.
  assign capture  = bus.m1_start &&
                    (state_q == ST_IDLE || state_q == ST_OFF_WAIT || state_q == ST_WAIT_END);
  assign is_entry = !dos_q && trdos_en_q && rom48_q && romnram_q && (za_q[15:8] == ENTRY_HI);
  assign is_exit  = dos_q && !romnram_q && (za_q >= RAM_BASE);

  always_comb begin
    state_d     = state_q;
    za_d        = za_q;
    romnram_d   = romnram_q;
    rom48_d     = rom48_q;
    dos_d       = dos_q;
    cpm_n_d     = cpm_n_q;
    trdos_en_d  = trdos_en_q;
    tmo_d       = tmo_q;
    entry_cnt_d = entry_cnt_q;
    on_d        = 1'b0;
    off_d       = 1'b0;

    if (capture) begin
      za_d       = bus.za;
      romnram_d  = bus.romnram;
      rom48_d    = bus.rom48;
      dos_d      = bus.dos;
      cpm_n_d    = bus.cpm_n;
      trdos_en_d = bus.trdos_en;
      state_d    = ST_DECODE;
    end else begin
      case (state_q)
        ST_DECODE: begin
          tmo_d = 8'd0;
          if (!cpm_n_q) begin
            state_d = ST_WAIT_END;
          end else if (is_entry) begin
            state_d = ST_ON;
            on_d    = 1'b1;
            if (entry_cnt_q != 8'hFF) entry_cnt_d = entry_cnt_q + 8'd1;
          end else if (is_exit) begin
            state_d = ST_OFF_WAIT;
          end else begin
            state_d = ST_WAIT_END;
          end
        end
        ST_ON: begin
          tmo_d   = 8'd0;
          state_d = ST_WAIT_END;
        end
        ST_OFF_WAIT: begin
          // cpm_n is not rechecked here: the mode captured at the fetch decides.
          if (bus.cycle_end) begin
            off_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (tmo_q >= TIMEOUT - 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        ST_WAIT_END: begin
          if (bus.cycle_end || (tmo_q >= TIMEOUT - 8'd1)) begin
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      za_q        <= 16'h0000;
      romnram_q   <= 1'b0;
      rom48_q     <= 1'b0;
      dos_q       <= 1'b0;
      cpm_n_q     <= 1'b1;
      trdos_en_q  <= 1'b0;
      tmo_q       <= 8'd0;
      entry_cnt_q <= 8'd0;
      on_q        <= 1'b0;
      off_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      za_q        <= za_d;
      romnram_q   <= romnram_d;
      rom48_q     <= rom48_d;
      dos_q       <= dos_d;
      cpm_n_q     <= cpm_n_d;
      trdos_en_q  <= trdos_en_d;
      tmo_q       <= tmo_d;
      entry_cnt_q <= entry_cnt_d;
      on_q        <= on_d;
      off_q       <= off_d;
    end
  end

  assign bus.dos_turn_on  = on_q;
  assign bus.dos_turn_off = off_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.entry_cnt    = entry_cnt_q;
  assign bus.fsm_state    = state_q;

endmodule
